// File: rtl/fetch_unit.sv
// MIPS instruction fetch: holds the PC, fetches over a req/ready handshake and computes the next PC on retire.
// One FETCH cycle minimum per word; waits in HOLD until instr_done, errors out if memory stalls for TIMEOUT cycles.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        beq,
    input  logic        bne,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [31:0] retired,
    output logic        fetch_err,
    output logic        addr_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    state_t          state;
    logic [CW-1:0]   tcnt;
    logic [31:0]     next_pc;
    logic [31:0]     br_off;
    logic            jr_mis;

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign jr_mis    = (jr_target[1:0] != 2'b00);

    always_comb begin
        br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc = pc_plus4;
        if (jr)
            next_pc = {jr_target[31:2], 2'b00};
        else if (j || jal)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if ((beq && zero) || (bne && !zero))
            next_pc = pc_plus4 + br_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            retired     <= 32'd0;
            fetch_err   <= 1'b0;
            addr_err    <= 1'b0;
            tcnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    tcnt  <= '0;
                end
                FETCH: begin
                    // ready on the last allowed cycle still counts as success
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (tcnt == TMAX) begin
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_done) begin
                        pc          <= next_pc;
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        tcnt        <= '0;
                        state       <= FETCH;
                        if (jr && jr_mis)
                            addr_err <= 1'b1;
                    end
                end
                ERR: begin
                    fetch_err   <= 1'b1;
                    instr_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fetch_unit;

    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_done = 1'b0;
    logic        beq = 1'b0, bne = 1'b0, j = 1'b0, jal = 1'b0, jr = 1'b0, zero = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] retired;
    logic        fetch_err;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // model: phase 0 idle, 1 fetching, 2 holding an instruction, 3 dead after timeout
    int          m_ph;
    int          m_wait;
    logic [31:0] m_pc, m_instr, m_ret;
    logic        m_aerr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .instr_done(instr_done), .beq(beq), .bne(bne), .j(j), .jal(jal), .jr(jr), .zero(zero),
        .jr_target(jr_target), .retired(retired), .fetch_err(fetch_err), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input logic [31:0] tgt, input logic b, input logic bn,
                                               input logic jj, input logic jl, input logic r,
                                               input logic z);
        logic [31:0] seq;
        int off;
        seq = p + 32'd4;
        off = $signed(ins[15:0]);
        off = off * 4;
        if (r) return tgt & ~32'd3;
        if (jj || jl) return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} << 2);
        if ((b && z) || (bn && !z)) return seq + 32'(off);
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_wait <= 0; m_pc <= 32'd0; m_instr <= 32'd0; m_ret <= 32'd0; m_aerr <= 1'b0;
        end else begin
            case (m_ph)
                0: begin m_ph <= 1; m_wait <= 0; end
                1: begin
                    m_wait <= m_wait + 1;
                    if (imem_ready) begin
                        m_instr <= imem_rdata;
                        m_ph    <= 2;
                    end else if (m_wait + 1 == TOUT) begin
                        m_ph <= 3;
                    end
                end
                2: if (instr_done) begin
                    m_pc   <= model_next(m_pc, m_instr, jr_target, beq, bne, j, jal, jr, zero);
                    m_ret  <= m_ret + 32'd1;
                    m_ph   <= 1;
                    m_wait <= 0;
                    if (jr && jr_target[1:0] != 2'b00) m_aerr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req",    32'(imem_req),    32'(m_ph == 1));
            chk("m_addr",   imem_addr,        m_pc);
            chk("m_pc",     pc,               m_pc);
            chk("m_pc4",    pc_plus4,         m_pc + 32'd4);
            chk("m_instr",  instr,            m_instr);
            chk("m_opcode", 32'(opcode),      32'(m_instr[31:26]));
            chk("m_valid",  32'(instr_valid), 32'(m_ph == 2));
            chk("m_retired", retired,         m_ret);
            chk("m_ferr",   32'(fetch_err),   32'(m_ph == 3));
            chk("m_aerr",   32'(addr_err),    32'(m_aerr));
        end
    end

    task automatic clear_in();
        imem_ready = 1'b0; instr_done = 1'b0;
        beq = 1'b0; bne = 1'b0; j = 1'b0; jal = 1'b0; jr = 1'b0; zero = 1'b0;
        jr_target = 32'd0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
    endtask

    // memory answers one cycle after the request appears
    task automatic fetch(input logic [31:0] w);
        wait_req();
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    task automatic retire(input logic b, input logic bn, input logic jj, input logic jl,
                          input logic r, input logic z, input logic [31:0] tgt);
        beq = b; bne = bn; j = jj; jal = jl; jr = r; zero = z; jr_target = tgt;
        instr_done = 1'b1;
        @(negedge clk);
        clear_in();
    endtask

    logic [31:0] words [3];

    initial begin
        int n;
        words[0] = 32'h0000_0000;
        words[1] = 32'h8C00_0000;
        words[2] = 32'hAC00_0000;
        clear_in();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            wait_req();
            chk("seq_addr", imem_addr, 32'(i * 4));
            fetch(words[i]);
            chk("seq_opcode", 32'(opcode), 32'(words[i][31:26]));
            retire(0, 0, 0, 0, 0, 0, 32'd0);
        end
        chk("seq_retired", retired, 32'd3);
        fetch(32'd0); retire(0, 0, 0, 0, 0, 0, 32'd0);
        chk("pc_10", imem_addr, 32'h10);

        fetch(32'h1000_FFFE); retire(1, 0, 0, 0, 0, 1, 32'd0);
        chk("beq_taken", imem_addr, 32'h0C);
        fetch(32'd0); retire(0, 0, 0, 0, 0, 0, 32'd0);
        fetch(32'h1000_FFFE); retire(1, 0, 0, 0, 0, 0, 32'd0);
        chk("beq_not_taken", imem_addr, 32'h14);
        fetch(32'd0); retire(0, 0, 0, 0, 1, 0, 32'h10);
        fetch(32'h1400_0003); retire(0, 1, 0, 0, 0, 0, 32'd0);
        chk("bne_taken", imem_addr, 32'h20);

        fetch(32'd0); retire(0, 0, 0, 0, 1, 0, 32'h3000_0040);
        chk("jr_far", imem_addr, 32'h3000_0040);
        fetch(32'h0C00_0100);
        chk("jal_pc4", pc_plus4, 32'h3000_0044);
        retire(0, 0, 0, 1, 0, 0, 32'd0);
        chk("jal_target", imem_addr, 32'h3000_0400);
        fetch(32'h0800_0000); retire(0, 0, 1, 0, 1, 0, 32'h200);
        chk("jr_priority", imem_addr, 32'h200);
        chk("aerr_clear", 32'(addr_err), 32'd0);

        fetch(32'd0); retire(0, 0, 0, 0, 1, 0, 32'h103);
        chk("jr_mis_pc", imem_addr, 32'h100);
        chk("jr_mis_aerr", 32'(addr_err), 32'd1);
        fetch(32'd0); retire(0, 0, 0, 0, 0, 0, 32'd0);
        chk("aerr_sticky", 32'(addr_err), 32'd1);
        chk("after_mis_pc", imem_addr, 32'h104);

        fetch(32'd0); retire(0, 0, 0, 0, 1, 0, 32'h40);
        fetch(32'h1234_5678);
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_pc", pc, 32'h40);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_aerr", 32'(addr_err), 32'd0);
        chk("arst_retired", retired, 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        // ready arrives on the last permitted FETCH cycle
        wait_req();
        repeat (TOUT - 1) @(negedge clk);
        chk("late_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("late_ok_valid", 32'(instr_valid), 32'd1);
        chk("late_ok_ferr", 32'(fetch_err), 32'd0);
        retire(0, 0, 0, 0, 0, 0, 32'd0);

        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", 32'(n), 32'(TOUT));
        chk("timeout_ferr", 32'(fetch_err), 32'd1);
        instr_done = 1'b1;
        repeat (5) @(negedge clk);
        instr_done = 1'b0;
        chk("err_req", 32'(imem_req), 32'd0);
        chk("err_valid", 32'(instr_valid), 32'd0);
        chk("err_ferr", 32'(fetch_err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n      = ((cyc % 700) != 699);
            imem_ready = ($urandom % 3) != 0;
            imem_rdata = $urandom;
            instr_done = $urandom % 2 == 0;
            beq        = $urandom % 4 == 0;
            bne        = $urandom % 4 == 0;
            j          = $urandom % 6 == 0;
            jal        = $urandom % 6 == 0;
            jr         = $urandom % 8 == 0;
            zero       = $urandom % 2 == 0;
            jr_target  = $urandom;
        end
        @(negedge clk);
        clear_in();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
